// File: rtl/sample_hold_pkg.sv
// Shared types and constants for the sample-and-hold latch controller.
package sample_hold_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    OPEN,
    HOLD,
    DONE
  } state_e;

  // Counter preload that keeps the latch transparent for open_cycles cycles.
  function automatic logic [CNT_W-1:0] open_load(input int unsigned open_cycles);
    return CNT_W'(open_cycles - 1);
  endfunction

endpackage

// File: rtl/d_latch.sv
// Level-sensitive transparent latch modelling the downstream storage element.
module d_latch #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  always_latch begin
    if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/window_cnt.sv
// Down-counter timing the transparent window of the downstream latch.
module window_cnt
  import sample_hold_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  // Saturates at zero so a stray enable can never wrap the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/sample_hold_ctrl.sv
// Drives a transparent latch through setup/open/hold phases and returns its readback.
module sample_hold_ctrl
  import sample_hold_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned OPEN_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] lat_d,
  output logic             lat_en,
  input  logic [WIDTH-1:0] lat_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             err
);

  localparam logic [CNT_W-1:0] OpenLoad = open_load(OPEN_CYCLES);

  state_e           state_q;
  logic [WIDTH-1:0] lat_d_q;
  logic [WIDTH-1:0] dout_q;
  logic             lat_en_q;
  logic             out_valid_q;
  logic             req_ready_q;
  logic             err_q;
  logic             cnt_load;
  logic             cnt_en;
  logic             cnt_zero;

  assign cnt_load = (state_q == SETUP);
  assign cnt_en   = (state_q == OPEN);

  window_cnt u_window_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (OpenLoad),
    .zero     (cnt_zero)
  );

  // All outputs are registered so lat_en cannot glitch while the latch is driven.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lat_d_q     <= '0;
      dout_q      <= '0;
      lat_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            lat_d_q     <= din;
            req_ready_q <= 1'b0;
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          lat_en_q <= 1'b1;
          state_q  <= OPEN;
        end
        OPEN: begin
          if (cnt_zero) begin
            lat_en_q <= 1'b0;
            state_q  <= HOLD;
          end
        end
        HOLD: begin
          // lat_d is still held here, so the readback is compared against it directly.
          dout_q      <= lat_q;
          out_valid_q <= 1'b1;
          if (lat_q != lat_d_q) begin
            err_q <= 1'b1;
          end
          state_q <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign lat_d     = lat_d_q;
  assign lat_en    = lat_en_q;
  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign err       = err_q;

endmodule
